// File: rtl/fetch_ctrl_if.sv
// rtl/fetch_ctrl_if.sv - fetch controller memory, redirect and decode-side signal bundle
interface fetch_ctrl_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        halted;
  logic        fetch_err;

  modport master (
    output mem_addr, out_valid, out_instr, out_pc, halted, fetch_err,
    input  mem_instr, redirect_valid, redirect_pc, halt_req, out_ready
  );

  modport slave (
    input  mem_addr, out_valid, out_instr, out_pc, halted, fetch_err,
    output mem_instr, redirect_valid, redirect_pc, halt_req, out_ready
  );
endinterface

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction fetch controller with 2-entry output buffer
// Optional misaligned-redirect trap: define FETCH_MISALIGN_TRAP_EN.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_WORDS = 32
) (
  input  logic      clk,
  input  logic      rst,
  fetch_ctrl_if.master bus
);

  typedef enum logic {FETCH = 1'b0, HALTED = 1'b1} state_t;

  localparam logic [31:0] PC_SPAN = 32'(MEM_WORDS * 4);

  state_t      state, state_nxt;
  logic [31:0] fetch_pc, pc_inc, redir_target;
  logic [31:0] head_pc, head_instr, tail_pc, tail_instr;
  logic [1:0]  count;
  logic        pop, fill, redir_ok, misalign, fill_head;

  always_comb begin
    state_nxt    = state;
    pop          = (count != 2'd0) && bus.out_ready;
    fill         = 1'b0;
    redir_ok     = 1'b0;
    misalign     = 1'b0;
    redir_target = bus.redirect_pc & 32'hFFFF_FFFC;
    pc_inc       = fetch_pc + 32'd4;
    if (pc_inc >= PC_SPAN) pc_inc = 32'd0;
    if (bus.redirect_valid) begin
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign  = (bus.redirect_pc[1:0] != 2'b00);
`endif
      redir_ok  = !misalign;
      state_nxt = (misalign || bus.halt_req) ? HALTED : FETCH;
    end else if (state == FETCH) begin
      if (bus.halt_req) state_nxt = HALTED;
      else              fill = (count != 2'd2) || pop;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= state_nxt;
  end

  // New word lands in the head slot only if the buffer is empty after this cycle's pop.
  assign fill_head = (count == 2'd0) || (count == 2'd1 && pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc   <= RESET_PC;
      count      <= 2'd0;
      head_pc    <= 32'd0;
      head_instr <= 32'd0;
      tail_pc    <= 32'd0;
      tail_instr <= 32'd0;
    end else if (bus.redirect_valid) begin
      count <= 2'd0;
      if (redir_ok) fetch_pc <= redir_target;
    end else begin
      count <= count + {1'b0, fill} - {1'b0, pop};
      if (pop) begin
        head_pc    <= tail_pc;
        head_instr <= tail_instr;
      end
      if (fill) begin
        fetch_pc <= pc_inc;
        if (fill_head) begin
          head_pc    <= fetch_pc;
          head_instr <= bus.mem_instr;
        end else begin
          tail_pc    <= fetch_pc;
          tail_instr <= bus.mem_instr;
        end
      end
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_q | misalign;
  end
  assign bus.fetch_err = err_q;
`else
  assign bus.fetch_err = 1'b0;
`endif

  assign bus.mem_addr  = fetch_pc;
  assign bus.out_valid = (count != 2'd0);
  assign bus.out_pc    = head_pc;
  assign bus.out_instr = head_instr;
  assign bus.halted    = (state == HALTED);

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - self-checking bench for fetch_ctrl
module tb_fetch_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_ctrl_if bus();
  fetch_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  logic [31:0] mem [32];
  assign bus.mem_instr = mem[bus.mem_addr[6:2]];

  int checks = 0;
  int errors = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(bit r, bit rv, logic [31:0] rpc, bit h, bit rdy);
    @(negedge clk);
    rst = r; bus.redirect_valid = rv; bus.redirect_pc = rpc;
    bus.halt_req = h; bus.out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic r, rv; logic [31:0] rpc; logic h, rdy;
    logic ev; logic [31:0] epc, eaddr; logic eh;
  } vec_t;
  localparam int NV = 23;
  vec_t tbl [NV];

  // Reference: buffer as a queue, sequential program counter, halted flag.
  typedef struct packed { logic [31:0] pc; logic [31:0] instr; } ent_t;
  ent_t mq[$];
  logic [31:0] mpc;
  bit mhalt, merr;

  task automatic model_step(bit r, bit rv, logic [31:0] rpc, bit h, bit rdy);
    if (r) begin
      mq.delete(); mpc = 32'd0; mhalt = 0; merr = 0;
    end else if (rv) begin
      mq.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
      if (rpc[1:0] != 2'b00) begin merr = 1; mhalt = 1; end
      else begin mpc = rpc; mhalt = h; end
`else
      mpc = rpc & 32'hFFFF_FFFC; mhalt = h;
`endif
    end else begin
      if (mq.size() > 0 && rdy) void'(mq.pop_front());
      if (!mhalt && !h) begin
        if (mq.size() < 2) begin
          mq.push_back({mpc, mem[mpc[6:2]]});
          mpc = (mpc + 32'd4) % 32'd128;
        end
      end else mhalt = 1;
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = ($urandom() & 32'hFFFF_FF00) | i;
    rst = 1; bus.redirect_valid = 0; bus.redirect_pc = 0; bus.halt_req = 0; bus.out_ready = 0;

    //            r  rv rpc     h  rdy ev epc     eaddr   eh
    tbl[0]  = '{1'b1,1'b0,32'h00,1'b0,1'b0,1'b0,32'h00,32'h00,1'b0};
    tbl[1]  = '{1'b0,1'b0,32'h00,1'b0,1'b0,1'b1,32'h00,32'h04,1'b0};
    tbl[2]  = '{1'b0,1'b0,32'h00,1'b0,1'b0,1'b1,32'h00,32'h08,1'b0};
    tbl[3]  = '{1'b0,1'b0,32'h00,1'b0,1'b0,1'b1,32'h00,32'h08,1'b0};
    tbl[4]  = '{1'b0,1'b0,32'h00,1'b0,1'b0,1'b1,32'h00,32'h08,1'b0};
    tbl[5]  = '{1'b0,1'b0,32'h00,1'b0,1'b1,1'b1,32'h04,32'h0C,1'b0};
    tbl[6]  = '{1'b0,1'b0,32'h00,1'b0,1'b1,1'b1,32'h08,32'h10,1'b0};
    tbl[7]  = '{1'b0,1'b1,32'h40,1'b0,1'b1,1'b0,32'h00,32'h40,1'b0};
    tbl[8]  = '{1'b0,1'b0,32'h00,1'b0,1'b1,1'b1,32'h40,32'h44,1'b0};
    tbl[9]  = '{1'b0,1'b0,32'h00,1'b0,1'b0,1'b1,32'h40,32'h48,1'b0};
    tbl[10] = '{1'b0,1'b0,32'h00,1'b1,1'b0,1'b1,32'h40,32'h48,1'b1};
    tbl[11] = '{1'b0,1'b0,32'h00,1'b0,1'b1,1'b1,32'h44,32'h48,1'b1};
    tbl[12] = '{1'b0,1'b0,32'h00,1'b0,1'b1,1'b0,32'h00,32'h48,1'b1};
    tbl[13] = '{1'b0,1'b0,32'h00,1'b0,1'b1,1'b0,32'h00,32'h48,1'b1};
    tbl[14] = '{1'b0,1'b1,32'h10,1'b0,1'b1,1'b0,32'h00,32'h10,1'b0};
    tbl[15] = '{1'b0,1'b0,32'h00,1'b0,1'b1,1'b1,32'h10,32'h14,1'b0};
    tbl[16] = '{1'b0,1'b1,32'h7C,1'b0,1'b1,1'b0,32'h00,32'h7C,1'b0};
    tbl[17] = '{1'b0,1'b0,32'h00,1'b0,1'b1,1'b1,32'h7C,32'h00,1'b0};
    tbl[18] = '{1'b0,1'b0,32'h00,1'b0,1'b1,1'b1,32'h00,32'h04,1'b0};
    tbl[19] = '{1'b0,1'b0,32'h00,1'b0,1'b0,1'b1,32'h00,32'h08,1'b0};
    tbl[20] = '{1'b1,1'b0,32'h00,1'b0,1'b1,1'b0,32'h00,32'h00,1'b0};
    tbl[21] = '{1'b0,1'b1,32'h20,1'b1,1'b1,1'b0,32'h00,32'h20,1'b1};
    tbl[22] = '{1'b0,1'b0,32'h00,1'b0,1'b1,1'b0,32'h00,32'h20,1'b1};

    for (int i = 0; i < NV; i++) begin
      apply(tbl[i].r, tbl[i].rv, tbl[i].rpc, tbl[i].h, tbl[i].rdy);
      check($sformatf("tbl%0d out_valid", i), {31'd0, bus.out_valid}, {31'd0, tbl[i].ev});
      check($sformatf("tbl%0d mem_addr", i), bus.mem_addr, tbl[i].eaddr);
      check($sformatf("tbl%0d halted", i), {31'd0, bus.halted}, {31'd0, tbl[i].eh});
      check($sformatf("tbl%0d fetch_err", i), {31'd0, bus.fetch_err}, 32'd0);
      if (tbl[i].ev) begin
        check($sformatf("tbl%0d out_pc", i), bus.out_pc, tbl[i].epc);
        check($sformatf("tbl%0d out_instr", i), bus.out_instr, mem[tbl[i].epc[6:2]]);
      end
      if (tbl[i].r) begin
        check($sformatf("tbl%0d rst out_pc", i), bus.out_pc, 32'd0);
        check($sformatf("tbl%0d rst out_instr", i), bus.out_instr, 32'd0);
      end
    end

    // Misaligned redirect after three fetches (fetch_pc = 0x0C)
    apply(1, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) apply(0, 0, 0, 0, 1);
    apply(0, 1, 32'h42, 0, 1);
    check("mis out_valid", {31'd0, bus.out_valid}, 32'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
    check("mis fetch_err", {31'd0, bus.fetch_err}, 32'd1);
    check("mis halted", {31'd0, bus.halted}, 32'd1);
    check("mis mem_addr", bus.mem_addr, 32'h0C);
    apply(0, 0, 0, 0, 1);
    check("mis hold valid", {31'd0, bus.out_valid}, 32'd0);
    check("mis hold err", {31'd0, bus.fetch_err}, 32'd1);
`else
    check("mis fetch_err", {31'd0, bus.fetch_err}, 32'd0);
    check("mis halted", {31'd0, bus.halted}, 32'd0);
    check("mis mem_addr", bus.mem_addr, 32'h40);
    apply(0, 0, 0, 0, 1);
    check("mis resume valid", {31'd0, bus.out_valid}, 32'd1);
    check("mis resume pc", bus.out_pc, 32'h40);
`endif

    // Randomized run against the queue model
    for (int n = 0; n < 3000; n++) begin
      bit r, rv, h, rdy;
      logic [31:0] rpc;
      r   = (n == 0) || ($urandom_range(0, 99) == 0);
      rv  = ($urandom_range(0, 19) == 0);
      h   = ($urandom_range(0, 24) == 0);
      rdy = ($urandom_range(0, 9) < 7);
      rpc = $urandom_range(0, 127);
      if ($urandom_range(0, 3) != 0) rpc = rpc & 32'hFFFF_FFFC;
      model_step(r, rv, rpc, h, rdy);
      apply(r, rv, rpc, h, rdy);
      check("rnd out_valid", {31'd0, bus.out_valid}, {31'd0, mq.size() != 0});
      check("rnd mem_addr", bus.mem_addr, mpc);
      check("rnd halted", {31'd0, bus.halted}, {31'd0, mhalt});
      check("rnd fetch_err", {31'd0, bus.fetch_err}, {31'd0, merr});
      if (mq.size() != 0) begin
        check("rnd out_pc", bus.out_pc, mq[0].pc);
        check("rnd out_instr", bus.out_instr, mq[0].instr);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
